// File: rtl/io_mux_arbiter_if.sv
// Bundle of the request, data and grant signals exchanged between the two
// requesters and the io_mux_arbiter that shares one routing mux between them.
interface io_mux_arbiter_if #(
    parameter int WIDTH = 1
);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic             gnt0;
    logic             gnt1;
    logic             sel;
    logic [WIDTH-1:0] o;
    logic             o_valid;

    modport master (
        output req0, req1, d0, d1,
        input  gnt0, gnt1, sel, o, o_valid
    );

    modport slave (
        input  req0, req1, d0, d1,
        output gnt0, gnt1, sel, o, o_valid
    );
endinterface

// File: rtl/io_mux_arbiter.sv
// Bounded-hold round-robin arbiter that owns a two-input routing mux and
// registers its output, with a one-cycle break-before-make gap on handover.
module io_mux_arbiter #(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    io_mux_arbiter_if.slave    bus
);
    localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = (MAX_HOLD > 0) ? CW'(MAX_HOLD) : '1;

    typedef enum logic [1:0] {IDLE, GNT0, GNT1, SWITCH} state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             sel_q, sel_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic             o_valid_q, o_valid_d;

    logic             idle_go;
    logic             idle_who;
    logic             own;
    logic             own_req;
    logic             oth_req;
    logic [WIDTH-1:0] own_d;
    logic             hold_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            sel_q     <= 1'b0;
            o_q       <= '0;
            o_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            sel_q     <= sel_d;
            o_q       <= o_d;
            o_valid_q <= o_valid_d;
        end
    end

    // Decisions shared by IDLE and the SWITCH fallback; ties go to whoever was not last.
    always_comb begin
        idle_go  = bus.req0 | bus.req1;
        idle_who = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
        own      = (state_q == GNT1);
        own_req  = own ? bus.req1 : bus.req0;
        oth_req  = own ? bus.req0 : bus.req1;
        own_d    = own ? bus.d1 : bus.d0;
        hold_hit = (MAX_HOLD != 0) && ((int'(cnt_q) + 1) >= MAX_HOLD);
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        o_d       = o_q;
        o_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (idle_go) begin
                    state_d = idle_who ? GNT1 : GNT0;
                    sel_d   = idle_who;
                    cnt_d   = '0;
                    last_d  = idle_who;
                end
            end
            GNT0, GNT1: begin
                if (own_req) begin
                    o_d       = own_d;
                    o_valid_d = 1'b1;
                    cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
                    if (hold_hit && oth_req) begin
                        state_d = SWITCH;
                        sel_d   = ~own;
                    end
                end else if (oth_req) begin
                    state_d = SWITCH;
                    sel_d   = ~own;
                end else begin
                    state_d = IDLE;
                end
            end
            SWITCH: begin
                // sel already points at the target while in SWITCH.
                if (sel_q ? bus.req1 : bus.req0) begin
                    state_d = sel_q ? GNT1 : GNT0;
                    cnt_d   = '0;
                    last_d  = sel_q;
                end else if (idle_go) begin
                    state_d = idle_who ? GNT1 : GNT0;
                    sel_d   = idle_who;
                    cnt_d   = '0;
                    last_d  = idle_who;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        gnt0_d = (state_d == GNT0);
        gnt1_d = (state_d == GNT1);
    end

    assign bus.gnt0    = gnt0_q;
    assign bus.gnt1    = gnt1_q;
    assign bus.sel     = sel_q;
    assign bus.o       = o_q;
    assign bus.o_valid = o_valid_q;
endmodule

// File: tb/tb_io_mux_arbiter.sv
// Self-checking bench for io_mux_arbiter: a hand-derived vector table fed
// through an expectation queue, plus reset, tie and unlimited-hold sequences.
module tb_io_mux_arbiter;
    logic clk;
    logic rst_n;

    io_mux_arbiter_if #(.WIDTH(4)) bus();
    io_mux_arbiter_if #(.WIDTH(4)) bus_nh();

    io_mux_arbiter #(.WIDTH(4), .MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    io_mux_arbiter #(.WIDTH(4), .MAX_HOLD(0)) dut_nh (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_nh.slave)
    );

    assign bus_nh.req0 = bus.req0;
    assign bus_nh.req1 = bus.req1;
    assign bus_nh.d0   = bus.d0;
    assign bus_nh.d1   = bus.d1;

    typedef struct {
        logic       req0;
        logic       req1;
        logic [3:0] d0;
        logic [3:0] d1;
        logic       gnt0;
        logic       gnt1;
        logic       sel;
        logic [3:0] o;
        logic       o_valid;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_applied;
    int   n_miscompare;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miscompare++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic r0, input logic r1, input logic [3:0] a, input logic [3:0] b,
                          input logic g0, input logic g1, input logic s, input logic [3:0] o,
                          input logic ov);
        vec_t v;
        v.req0 = r0; v.req1 = r1; v.d0 = a; v.d1 = b;
        v.gnt0 = g0; v.gnt1 = g1; v.sel = s; v.o = o; v.o_valid = ov;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        bus.req0 = v.req0;
        bus.req1 = v.req1;
        bus.d0   = v.d0;
        bus.d1   = v.d1;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input int idx);
        vec_t e;
        if (exp_q.size() == 0) begin
            check($sformatf("v%0d scoreboard_empty", idx), 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("v%0d gnt0", idx), 32'(bus.gnt0), 32'(e.gnt0));
            check($sformatf("v%0d gnt1", idx), 32'(bus.gnt1), 32'(e.gnt1));
            check($sformatf("v%0d sel", idx), 32'(bus.sel), 32'(e.sel));
            check($sformatf("v%0d o", idx), 32'(bus.o), 32'(e.o));
            check($sformatf("v%0d o_valid", idx), 32'(bus.o_valid), 32'(e.o_valid));
            check($sformatf("v%0d gnt_excl", idx), 32'(bus.gnt0 & bus.gnt1), 32'd0);
        end
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, " gnt0"}, 32'(bus.gnt0), 32'd0);
        check({tag, " gnt1"}, 32'(bus.gnt1), 32'd0);
        check({tag, " sel"}, 32'(bus.sel), 32'd0);
        check({tag, " o"}, 32'(bus.o), 32'd0);
        check({tag, " o_valid"}, 32'(bus.o_valid), 32'd0);
        check({tag, " nh_gnt0"}, 32'(bus_nh.gnt0), 32'd0);
    endtask

    initial begin
        n_applied    = 0;
        n_miscompare = 0;
        rst_n    = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.d0   = '0;
        bus.d1   = '0;

        //     r0 r1 d0    d1    | g0 g1 sel o     ov
        // single burst from requester 0
        addVec(0, 0, 4'h0, 4'h0,   0, 0, 0, 4'h0, 0);
        addVec(1, 0, 4'hF, 4'h0,   1, 0, 0, 4'h0, 0);
        addVec(1, 0, 4'h1, 4'h0,   1, 0, 0, 4'h1, 1);
        addVec(1, 0, 4'h2, 4'h0,   1, 0, 0, 4'h2, 1);
        addVec(1, 0, 4'h3, 4'h0,   1, 0, 0, 4'h3, 1);
        addVec(0, 0, 4'h9, 4'h0,   0, 0, 0, 4'h3, 0);
        addVec(0, 0, 4'h0, 4'h0,   0, 0, 0, 4'h3, 0);
        // tie with last=0 goes to requester 1, then hold-limit alternation
        addVec(1, 1, 4'hA, 4'h5,   0, 1, 1, 4'h3, 0);
        addVec(1, 1, 4'hA, 4'h1,   0, 1, 1, 4'h1, 1);
        addVec(1, 1, 4'hA, 4'h2,   0, 1, 1, 4'h2, 1);
        addVec(1, 1, 4'hA, 4'h3,   0, 1, 1, 4'h3, 1);
        addVec(1, 1, 4'hA, 4'h4,   0, 0, 0, 4'h4, 1);
        addVec(1, 1, 4'h6, 4'h7,   1, 0, 0, 4'h4, 0);
        addVec(1, 1, 4'h8, 4'h7,   1, 0, 0, 4'h8, 1);
        addVec(1, 1, 4'h9, 4'h7,   1, 0, 0, 4'h9, 1);
        addVec(1, 1, 4'hA, 4'h7,   1, 0, 0, 4'hA, 1);
        addVec(1, 1, 4'hB, 4'h7,   0, 0, 1, 4'hB, 1);
        addVec(1, 1, 4'h0, 4'hC,   0, 1, 1, 4'hB, 0);
        // release handover from requester 1 to requester 0
        addVec(1, 1, 4'h0, 4'hD,   0, 1, 1, 4'hD, 1);
        addVec(1, 0, 4'h0, 4'hE,   0, 0, 0, 4'hD, 0);
        addVec(1, 0, 4'h0, 4'h0,   1, 0, 0, 4'hD, 0);
        // vanishing target: req1 drops during SWITCH
        addVec(1, 0, 4'h1, 4'h0,   1, 0, 0, 4'h1, 1);
        addVec(0, 1, 4'h0, 4'h0,   0, 0, 1, 4'h1, 0);
        addVec(1, 0, 4'h0, 4'hF,   1, 0, 0, 4'h1, 0);
        // hold limit reached alone, then late arrival of requester 1
        addVec(1, 0, 4'h2, 4'hF,   1, 0, 0, 4'h2, 1);
        addVec(1, 0, 4'h3, 4'h0,   1, 0, 0, 4'h3, 1);
        addVec(1, 0, 4'h4, 4'h0,   1, 0, 0, 4'h4, 1);
        addVec(1, 0, 4'h5, 4'h0,   1, 0, 0, 4'h5, 1);
        addVec(1, 0, 4'h6, 4'h0,   1, 0, 0, 4'h6, 1);
        addVec(1, 1, 4'h7, 4'h0,   0, 0, 1, 4'h7, 1);
        addVec(1, 1, 4'h0, 4'h0,   0, 1, 1, 4'h7, 0);
        // release to IDLE: sel holds its last value
        addVec(0, 0, 4'h0, 4'h0,   0, 0, 1, 4'h7, 0);
        addVec(0, 0, 4'h0, 4'h0,   0, 0, 1, 4'h7, 0);

        repeat (3) @(posedge clk);
        #1;
        checkResetValues("reset_initial");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(i);
        end

        // reset in the middle of a burst clears everything asynchronously
        @(negedge clk);
        bus.req0 = 1'b1;
        bus.d0   = 4'h0;
        @(negedge clk);
        bus.d0 = 4'h5;
        @(posedge clk);
        #1;
        check("burst_before_reset o", 32'(bus.o), 32'h5);
        check("burst_before_reset o_valid", 32'(bus.o_valid), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkResetValues("reset_async");
        bus.req0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkResetValues("reset_release");

        // tie right after reset goes to requester 0
        @(negedge clk);
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        bus.d0   = 4'h1;
        @(posedge clk);
        #1;
        check("tie gnt0", 32'(bus.gnt0), 32'd1);
        check("tie gnt1", 32'(bus.gnt1), 32'd0);
        check("tie sel", 32'(bus.sel), 32'd0);
        check("tie nh_gnt0", 32'(bus_nh.gnt0), 32'd1);

        // with unlimited hold, requester 0 keeps the path while requester 1 waits
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus.d0 = 4'(k + 2);
            @(posedge clk);
            #1;
            check($sformatf("nh%0d gnt0", k), 32'(bus_nh.gnt0), 32'd1);
            check($sformatf("nh%0d gnt1", k), 32'(bus_nh.gnt1), 32'd0);
            check($sformatf("nh%0d o", k), 32'(bus_nh.o), 32'(k + 2));
            check($sformatf("nh%0d o_valid", k), 32'(bus_nh.o_valid), 32'd1);
            check($sformatf("nh%0d excl", k), 32'(bus.gnt0 & bus.gnt1), 32'd0);
        end

        @(negedge clk);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompare);
        $finish;
    end
endmodule
